// File: rtl/z80_bus_arbiter.sv
// -----------------------------------------------------------------------------
// z80_bus_arbiter
//
// Lets a DMA master borrow the Z80 bus through the BUSREQ/BUSACK handshake.
// Sequence per tenure: IDLE -> REQ -> GRANT -> RELEASE -> GAP -> IDLE.
// A request that is withdrawn before the Z80 acknowledges is never granted
// (REQ -> RELEASE). After every tenure the CPU keeps the bus for MIN_GAP
// cycles before a new request is accepted.
//
// Optional feature, compile-time macro Z80_ARB_HOLD_LIMIT_EN:
//   defined     -> a tenure is cut after MAX_HOLD grant cycles and dma_yield
//                  pulses for one cycle; the DMA master re-arbitrates later.
//   not defined -> no hold limit, no hold counter, dma_yield is constant 0.
//
// Parameters:
//   MAX_HOLD  max consecutive grant cycles (2..255), hold-limit build only
//   MIN_GAP   CPU-owned cycles between two DMA tenures (1..15)
//
// Ports:
//   clk        in   sole clock, rising edge
//   rst        in   asynchronous active-high reset
//   dma_req    in   DMA master request, held high for the whole tenure
//   dma_gnt    out  DMA master owns the bus while high
//   dma_yield  out  one-cycle pulse: grant withdrawn by the hold limit
//   BUSREQ_L   out  active-low bus request to the Z80
//   BUSACK_L   in   active-low bus acknowledge, synchronous to clk
//   busy       out  high whenever the arbiter is not in IDLE
//
// All outputs are registered: each is computed from the next state and
// loaded on the same edge as the state register.
// -----------------------------------------------------------------------------
module z80_bus_arbiter #(
  parameter int MAX_HOLD = 64,
  parameter int MIN_GAP  = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic dma_req,
  output logic dma_gnt,
  output logic dma_yield,
  output logic BUSREQ_L,
  input  logic BUSACK_L,
  output logic busy
);

  // Elaboration-time parameter range guards.
  if (MIN_GAP < 1 || MIN_GAP > 15) begin : g_bad_min_gap
    $error("z80_bus_arbiter: MIN_GAP must be in 1..15");
  end
  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("z80_bus_arbiter: MAX_HOLD must be in 2..255");
  end

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_REQ     = 3'd1,
    S_GRANT   = 3'd2,
    S_RELEASE = 3'd3,
    S_GAP     = 3'd4
  } state_t;

  localparam logic [3:0] GAP_LAST = 4'(MIN_GAP - 1);

  state_t     r_state;
  state_t     w_state_next;
  logic       r_gnt;
  logic       r_busreq_l;
  logic       r_busy;
  logic [3:0] r_gap_cnt;

`ifdef Z80_ARB_HOLD_LIMIT_EN
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  logic [7:0] r_hold_cnt;
  logic       r_yield;
  logic       w_yield_next;
  logic       w_hold_hit;

  // Counter reads MAX_HOLD-1 during the last permitted grant cycle.
  assign w_hold_hit = (r_hold_cnt == HOLD_LAST);
`endif

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
`ifdef Z80_ARB_HOLD_LIMIT_EN
    w_yield_next = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        if (dma_req) w_state_next = S_REQ;
      end
      S_REQ: begin
        // Ack arrived: grant only if the DMA master still wants the bus,
        // otherwise hand the bus straight back (aborted request).
        if (!BUSACK_L) w_state_next = dma_req ? S_GRANT : S_RELEASE;
      end
      S_GRANT: begin
        // A voluntary release or a lost acknowledge has priority over the
        // hold limit, so neither of them raises dma_yield.
        if (!dma_req || BUSACK_L) begin
          w_state_next = S_RELEASE;
        end
`ifdef Z80_ARB_HOLD_LIMIT_EN
        else if (w_hold_hit) begin
          w_state_next = S_RELEASE;
          w_yield_next = 1'b1;
        end
`endif
      end
      S_RELEASE: begin
        if (BUSACK_L) w_state_next = S_GAP;
      end
      S_GAP: begin
        // dma_req and BUSACK_L are deliberately ignored here.
        if (r_gap_cnt == GAP_LAST) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // State, registered outputs and gap counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_gnt      <= 1'b0;
      r_busreq_l <= 1'b1;
      r_busy     <= 1'b0;
      r_gap_cnt  <= 4'd0;
    end else begin
      r_state    <= w_state_next;
      r_gnt      <= (w_state_next == S_GRANT);
      r_busreq_l <= !((w_state_next == S_REQ) || (w_state_next == S_GRANT));
      r_busy     <= (w_state_next != S_IDLE);
      // Held at zero outside GAP, so it is already cleared on entry.
      r_gap_cnt  <= (r_state == S_GAP) ? (r_gap_cnt + 4'd1) : 4'd0;
    end
  end

`ifdef Z80_ARB_HOLD_LIMIT_EN
  // Hold counter: zero outside GRANT, counts grant cycles inside it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hold_cnt <= 8'd0;
      r_yield    <= 1'b0;
    end else begin
      r_hold_cnt <= (r_state == S_GRANT) ? (r_hold_cnt + 8'd1) : 8'd0;
      r_yield    <= w_yield_next;
    end
  end

  assign dma_yield = r_yield;
`else
  assign dma_yield = 1'b0;
`endif

  assign dma_gnt  = r_gnt;
  assign BUSREQ_L = r_busreq_l;
  assign busy     = r_busy;

endmodule

// File: tb/tb_z80_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_z80_bus_arbiter
//
// Randomised DMA transfers against a Z80 acknowledge model. Each transfer is a
// request for L grant cycles. The reference model turns L into the list of
// grant tenures the arbiter should produce (hold-limit chunks, a cut made by
// a lost acknowledge or a reset) and queues them; a monitor measures every
// grant pulse on the pins and pops the queue to compare length and yield.
// The monitor also watches that dma_gnt only appears with an acknowledged
// request and that the CPU keeps the bus long enough between tenures.
// -----------------------------------------------------------------------------
module tb_z80_bus_arbiter;

  localparam int MAX_HOLD = 8;
  localparam int MIN_GAP  = 4;

  logic clk = 1'b0;
  logic rst;
  logic dma_req;
  logic BUSACK_L;
  logic dma_gnt;
  logic dma_yield;
  logic BUSREQ_L;
  logic busy;

  always #5 clk = ~clk;

  z80_bus_arbiter #(
    .MAX_HOLD (MAX_HOLD),
    .MIN_GAP  (MIN_GAP)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .dma_req   (dma_req),
    .dma_gnt   (dma_gnt),
    .dma_yield (dma_yield),
    .BUSREQ_L  (BUSREQ_L),
    .BUSACK_L  (BUSACK_L),
    .busy      (busy)
  );

  typedef struct {
    int len;
    bit yld;
  } tenure_t;

  tenure_t exp_q[$];

  int checks   = 0;
  int failures = 0;

  // Z80 model controls, written by the stimulus before each transfer.
  int ack_delay = 2;
  int rel_delay = 1;
  int viol_k    = 0;
  bit rst_seen  = 1'b0;
  bit ack_at_edge = 1'b1;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference model: expected tenures for a request of L grant cycles whose
  // first tenure is cut after 'cut' cycles (0 = no cut).
  task automatic push_plan(input int L, input int cut);
    int rem;
    tenure_t t;
    rem = L;
    if (cut > 0) begin
      t.len = cut; t.yld = 1'b0; exp_q.push_back(t);
      rem -= cut;
    end
`ifdef Z80_ARB_HOLD_LIMIT_EN
    while (rem > MAX_HOLD) begin
      t.len = MAX_HOLD; t.yld = 1'b1; exp_q.push_back(t);
      rem -= MAX_HOLD;
    end
`endif
    t.len = rem; t.yld = 1'b0; exp_q.push_back(t);
  endtask

  // BUSACK_L as the arbiter sees it at each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      ack_at_edge = BUSACK_L;
    end
  end

  // Z80 model: acknowledges ack_delay cycles after BUSREQ_L falls, releases
  // rel_delay cycles after it rises; optionally drops the acknowledge after
  // viol_k grant cycles (protocol violation).
  int  z_ack_cnt = 0;
  int  z_rel_cnt = 0;
  int  z_gnt_cnt = 0;
  bit  z_wait_rel = 1'b0;
  initial begin
    forever begin
      @(negedge clk);
      if (!BUSREQ_L) begin
        z_rel_cnt = 0;
        if (BUSACK_L && !z_wait_rel) begin
          z_ack_cnt++;
          if (z_ack_cnt >= ack_delay) begin
            BUSACK_L  = 1'b0;
            z_ack_cnt = 0;
          end
        end else if (!BUSACK_L && dma_gnt && viol_k != 0) begin
          z_gnt_cnt++;
          if (z_gnt_cnt == viol_k) begin
            BUSACK_L   = 1'b1;
            z_wait_rel = 1'b1;
            viol_k     = 0;
            z_gnt_cnt  = 0;
          end
        end
      end else begin
        z_wait_rel = 1'b0;
        z_ack_cnt  = 0;
        z_gnt_cnt  = 0;
        if (!BUSACK_L) begin
          z_rel_cnt++;
          if (z_rel_cnt >= rel_delay) begin
            BUSACK_L  = 1'b1;
            z_rel_cnt = 0;
          end
        end
      end
    end
  end

  // Monitor: measures grant tenures and compares them with the queue.
  int      m_run = 0;
  int      m_hi_run = 0;
  bit      m_prev_gnt = 1'b0;
  bit      m_prev_busreq = 1'b1;
  bit      m_hi_valid = 1'b0;
  tenure_t m_t;
  initial begin
    forever begin
      @(negedge clk);
      if (dma_gnt)
        check("gnt_only_when_acked", int'({BUSREQ_L, ack_at_edge}), 0);
      if (dma_yield)
        check("yield_on_grant_drop", int'(m_prev_gnt && !dma_gnt), 1);
      if (dma_gnt) begin
        m_run++;
      end else if (m_prev_gnt) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_grant: got grant of %0d cycles, expected none (t=%0t)",
                   m_run, $time);
        end else begin
          m_t = exp_q.pop_front();
          check("grant_len", m_run, m_t.len);
          check("grant_yield", int'(dma_yield), int'(m_t.yld));
        end
        m_run = 0;
      end
      if (BUSREQ_L) begin
        m_hi_run++;
        if (!m_prev_busreq) m_hi_valid = 1'b1;
      end else begin
        if (m_prev_busreq && m_hi_valid)
          check("cpu_gap_len_ok", int'(m_hi_run >= MIN_GAP + 2), 1);
        m_hi_run   = 0;
        m_hi_valid = 1'b0;
      end
      if (rst_seen) begin
        m_hi_valid = 1'b0;
        rst_seen   = 1'b0;
      end
      m_prev_gnt    = dma_gnt;
      m_prev_busreq = BUSREQ_L;
    end
  end

  // Leaves the caller just after a falling edge with the arbiter idle.
  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (busy) check("idle_timeout", int'(busy), 0);
  endtask

  // One-cycle asynchronous reset in the middle of a grant.
  task automatic do_reset();
    #2;
    rst = 1'b1;
    rst_seen = 1'b1;
    #1;
    check("rst_gnt_low", int'(dma_gnt), 0);
    check("rst_busy_low", int'(busy), 0);
    check("rst_busreq_high", int'(BUSREQ_L), 1);
    check("rst_yield_low", int'(dma_yield), 0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("req_after_rst_busreq", int'(BUSREQ_L), 0);
    check("req_after_rst_busy", int'(busy), 1);
  endtask

  // DMA master: requests the bus until it has had L grant cycles.
  task automatic xfer(input int L, input int d, input int k, input int rst_at, input int rd);
    int got;
    int lat;
    int rst_pt;
    bit chk_lat;
    bit first;
    got = 0; lat = 0; first = 1'b1; rst_pt = rst_at;
    wait_idle();
    ack_delay = d;
    rel_delay = rd;
    viol_k    = k;
    push_plan(L, (k > 0) ? k : rst_at);
    chk_lat = BUSACK_L;
    dma_req = 1'b1;
    while (got < L && lat < 4000) begin
      @(negedge clk);
      lat++;
      if (dma_gnt) begin
        got++;
        if (first) begin
          first = 1'b0;
          if (chk_lat) check("grant_latency", lat, d + 1);
        end
      end
      if (rst_pt > 0 && got == rst_pt) begin
        do_reset();
        rst_pt = 0;
      end
    end
    if (got < L) check("xfer_timeout", got, L);
    dma_req = 1'b0;
    $display("xfer len=%0d ack_dly=%0d viol_at=%0d rst_at=%0d granted=%0d cycles=%0d",
             L, d, k, rst_at, got, lat);
  endtask

  // Request withdrawn before the acknowledge arrives.
  task automatic abort_xfer();
    int n;
    wait_idle();
    ack_delay = 7;
    rel_delay = 2;
    viol_k    = 0;
    dma_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    dma_req = 1'b0;
    n = 0;
    while (ack_at_edge && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("abort_ack_seen", int'(ack_at_edge), 0);
    check("abort_release_after_ack", int'(BUSREQ_L), 1);
    wait_idle();
    check("abort_back_to_idle", int'(busy), 0);
    $display("abort ack_dly=7 ack_after=%0d cycles", n);
  endtask

  initial begin
    int L;
    int lim;
    int k;
    rst      = 1'b1;
    dma_req  = 1'b0;
    BUSACK_L = 1'b1;
    #1;
    check("reset_gnt", int'(dma_gnt), 0);
    check("reset_busreq", int'(BUSREQ_L), 1);
    check("reset_busy", int'(busy), 0);
    check("reset_yield", int'(dma_yield), 0);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b0;

    xfer(10, 3, 0, 0, 2);            // basic tenure
    xfer(100, 2, 0, 0, 1);           // long request
    abort_xfer();
    xfer(12, 2, 3, 0, 2);            // acknowledge lost during grant
    xfer(20, 2, 0, 7, 3);            // reset on grant cycle 7
    xfer(MAX_HOLD, 1, 0, 0, 1);      // release coincides with hold limit
    xfer(MAX_HOLD + 1, 1, 0, 0, 1);
    xfer(2 * MAX_HOLD, 4, 0, 0, 2);
    xfer(1, 1, 0, 0, 1);

    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 5) == 0) begin
        abort_xfer();
      end else begin
        L = $urandom_range(1, 40);
        lim = L;
`ifdef Z80_ARB_HOLD_LIMIT_EN
        if (lim > MAX_HOLD) lim = MAX_HOLD;
`endif
        k = 0;
        if (lim >= 2 && $urandom_range(0, 3) == 0) k = $urandom_range(1, lim - 1);
        xfer(L, $urandom_range(1, 6), k, 0, $urandom_range(1, 4));
      end
    end

    wait_idle();
    repeat (3) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    check("final_busy", int'(busy), 0);
    check("final_busreq", int'(BUSREQ_L), 1);
    check("final_gnt", int'(dma_gnt), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/z80_bus_arbiter.md
Z80_BUS_ARBITER -- requirements
Module: z80_bus_arbiter

Interface
REQ-001 Parameter MAX_HOLD, default 64: maximum consecutive cycles the DMA master holds the bus (range 2..255).
REQ-002 Parameter MIN_GAP, default 4: cycles the CPU keeps the bus between two DMA tenures (range 1..15).
REQ-003 Port clk  in  1  sole clock; all state changes on posedge clk.
REQ-004 Port rst  in  1  asynchronous, active-high reset.
REQ-005 Port dma_req  in  1  DMA master requests the bus; held high for the whole tenure.
REQ-006 Port dma_gnt  out  1  DMA master may drive addr/data/control while high.
REQ-007 Port dma_yield  out  1  one-cycle pulse: the grant was withdrawn by hold limit.
REQ-008 Port BUSREQ_L  out  1  active-low bus request to z80.
REQ-009 Port BUSACK_L  in  1  active-low bus acknowledge from z80, synchronous to clk.
REQ-010 Port busy  out  1  high in every state except IDLE.

Function
REQ-011 States SHALL be IDLE, REQ, GRANT, RELEASE, GAP; all outputs registered.
REQ-012 IDLE: dma_req=1 -> REQ next edge; BUSREQ_L low from that edge.
REQ-013 REQ: BUSREQ_L=0; on sampled BUSACK_L=0 -> GRANT if dma_req=1, else RELEASE (aborted request, no grant ever issued).
REQ-014 GRANT: dma_gnt=1, BUSREQ_L=0; 8-bit hold counter cleared on entry, +1 per cycle in GRANT.
REQ-015 GRANT with dma_req=0 sampled -> RELEASE; dma_gnt low same edge.
REQ-016 Hold limit: in GRANT, counter==MAX_HOLD-1 with dma_req=1 -> RELEASE; dma_gnt=0 and dma_yield=1 for exactly that one cycle. dma_gnt is therefore high for at most MAX_HOLD cycles.
REQ-017 dma_req=0 and hold limit on the same cycle: normal release, dma_yield stays 0.
REQ-018 RELEASE: BUSREQ_L=1, dma_gnt=0; stay until sampled BUSACK_L=1 -> GAP.
REQ-019 GAP: 4-bit counter cleared on entry; after MIN_GAP cycles -> IDLE; dma_req ignored during GAP.
REQ-020 BUSACK_L low while in IDLE or GAP: ignored, no state change.
REQ-021 BUSACK_L returning high while in GRANT (protocol violation): -> RELEASE with dma_gnt=0 next edge, dma_yield=0.
REQ-022 dma_gnt=1 SHALL only occur while BUSREQ_L=0 and BUSACK_L was sampled low.

Reset
REQ-023 rst high SHALL immediately force state IDLE, BUSREQ_L=1, dma_gnt=0, dma_yield=0, busy=0, counters 0, regardless of clk.
REQ-024 Reset mid-GRANT drops dma_gnt asynchronously; after release, arbitration restarts from IDLE with no memory of the prior tenure.

Configuration
REQ-025 Macro Z80_ARB_HOLD_LIMIT_EN defined: REQ-016/REQ-017 active, MAX_HOLD enforced.
REQ-026 Macro not defined: no hold limit, hold counter absent, dma_yield tied 0, GRANT left only via REQ-015/REQ-021; MAX_HOLD unused.

Verification
REQ-027 Basic: dma_req=1 at cycle 0, z80 model acks 3 cycles after BUSREQ_L falls, DMA holds 10 cycles -> BUSREQ_L low cycle 1, dma_gnt high cycles 4..13, BUSREQ_L high cycle 14, busy low MIN_GAP cycles after BUSACK_L rises.
REQ-028 Hold limit (macro on, MAX_HOLD=8): dma_req held high 100 cycles -> dma_gnt high exactly 8 cycles per tenure, dma_yield one pulse per tenure, >=4 cycles BUSREQ_L high between tenures.
REQ-029 Macro off, same stimulus as REQ-028 -> single continuous grant of ~100 cycles, dma_yield never 1.
REQ-030 Abort: dma_req pulses 2 cycles, ack arrives 5 cycles later -> dma_gnt never asserted, BUSREQ_L released the cycle after ack, state returns to IDLE.
REQ-031 Reset: assert rst for 1 cycle mid-GRANT (cycle 7 of tenure) -> dma_gnt and busy low before next posedge, BUSREQ_L=1; with dma_req still high, new REQ starts the cycle after rst deasserts.
REQ-032 Protocol violation: z80 model raises BUSACK_L during GRANT -> dma_gnt low next edge, RELEASE then GAP, dma_yield 0; bench also asserts REQ-022 every cycle.
